// File: rtl/axi4l_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave port among NUMM masters.
// One transaction outstanding at a time; responses are routed back to the granted master only.
module axi4l_arbiter #(
  parameter int NUMM = 3,
  parameter int AW   = 32,
  parameter int DW   = 32,
  localparam int IW  = $clog2(NUMM)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // upstream masters
  input  logic [NUMM-1:0]   i_m_awvalid,
  input  logic [AW-1:0]     i_m_awaddr  [NUMM],
  input  logic [2:0]        i_m_awprot  [NUMM],
  output logic [NUMM-1:0]   o_m_awready,
  input  logic [NUMM-1:0]   i_m_wvalid,
  input  logic [DW-1:0]     i_m_wdata   [NUMM],
  input  logic [DW/8-1:0]   i_m_wstrb   [NUMM],
  output logic [NUMM-1:0]   o_m_wready,
  output logic [NUMM-1:0]   o_m_bvalid,
  output logic [1:0]        o_m_bresp   [NUMM],
  input  logic [NUMM-1:0]   i_m_bready,
  input  logic [NUMM-1:0]   i_m_arvalid,
  input  logic [AW-1:0]     i_m_araddr  [NUMM],
  input  logic [2:0]        i_m_arprot  [NUMM],
  output logic [NUMM-1:0]   o_m_arready,
  output logic [NUMM-1:0]   o_m_rvalid,
  output logic [DW-1:0]     o_m_rdata   [NUMM],
  output logic [1:0]        o_m_rresp   [NUMM],
  input  logic [NUMM-1:0]   i_m_rready,
  // shared downstream port
  output logic              o_s_awvalid,
  output logic [AW-1:0]     o_s_awaddr,
  output logic [2:0]        o_s_awprot,
  input  logic              i_s_awready,
  output logic              o_s_wvalid,
  output logic [DW-1:0]     o_s_wdata,
  output logic [DW/8-1:0]   o_s_wstrb,
  input  logic              i_s_wready,
  input  logic              i_s_bvalid,
  input  logic [1:0]        i_s_bresp,
  output logic              o_s_bready,
  output logic              o_s_arvalid,
  output logic [AW-1:0]     o_s_araddr,
  output logic [2:0]        o_s_arprot,
  input  logic              i_s_arready,
  input  logic              i_s_rvalid,
  input  logic [DW-1:0]     i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  output logic              o_s_rready,
  // grant status
  output logic              o_gnt_valid,
  output logic [IW-1:0]     o_gnt_idx,
  output logic              o_gnt_write
);

  // states: IDLE arbitrate | WR_ADDR AW+W | WR_RESP B | RD_ADDR AR | RD_RESP R
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  logic [2:0]      r_state;
  logic [IW-1:0]   r_gnt_idx;
  logic            r_gnt_write;
  logic [IW-1:0]   r_last;
  logic [NUMM-1:0] r_last_type;
  logic            r_aw_done;
  logic            r_w_done;

  logic            w_found;
  logic            w_sel_write;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_scan;
  logic [NUMM-1:0] w_gnt_oh;
  logic            w_wa;
  logic            w_aw_open;
  logic            w_w_open;
  logic            w_aw_hs;
  logic            w_w_hs;

  // cyclic search starting one past the last winner
  always_comb begin
    w_found     = 1'b0;
    w_sel       = '0;
    w_sel_write = 1'b0;
    w_scan      = r_last;
    for (int k = 0; k < NUMM; k++) begin
      w_scan = (w_scan == IW'(NUMM - 1)) ? '0 : w_scan + 1'b1;
      if (!w_found && (i_m_awvalid[w_scan] || i_m_arvalid[w_scan])) begin
        w_found     = 1'b1;
        w_sel       = w_scan;
        w_sel_write = i_m_awvalid[w_scan] && (!i_m_arvalid[w_scan] || !r_last_type[w_scan]);
      end
    end
  end

  assign w_gnt_oh  = {{(NUMM-1){1'b0}}, 1'b1} << r_gnt_idx;
  assign w_wa      = (r_state == ST_WR_ADDR);
  assign w_aw_open = w_wa && !r_aw_done;
  assign w_w_open  = w_wa && !r_w_done;

  assign o_s_awvalid = w_aw_open && i_m_awvalid[r_gnt_idx];
  assign o_s_awaddr  = i_m_awaddr[r_gnt_idx];
  assign o_s_awprot  = i_m_awprot[r_gnt_idx];
  assign o_s_wvalid  = w_w_open && i_m_wvalid[r_gnt_idx];
  assign o_s_wdata   = i_m_wdata[r_gnt_idx];
  assign o_s_wstrb   = i_m_wstrb[r_gnt_idx];
  assign o_s_bready  = (r_state == ST_WR_RESP) && i_m_bready[r_gnt_idx];
  assign o_s_arvalid = (r_state == ST_RD_ADDR) && i_m_arvalid[r_gnt_idx];
  assign o_s_araddr  = i_m_araddr[r_gnt_idx];
  assign o_s_arprot  = i_m_arprot[r_gnt_idx];
  assign o_s_rready  = (r_state == ST_RD_RESP) && i_m_rready[r_gnt_idx];

  assign o_m_awready = w_gnt_oh & {NUMM{w_aw_open && i_s_awready}};
  assign o_m_wready  = w_gnt_oh & {NUMM{w_w_open && i_s_wready}};
  assign o_m_arready = w_gnt_oh & {NUMM{(r_state == ST_RD_ADDR) && i_s_arready}};
  assign o_m_bvalid  = w_gnt_oh & {NUMM{(r_state == ST_WR_RESP) && i_s_bvalid}};
  assign o_m_rvalid  = w_gnt_oh & {NUMM{(r_state == ST_RD_RESP) && i_s_rvalid}};

  always_comb begin
    for (int m = 0; m < NUMM; m++) begin
      o_m_bresp[m] = i_s_bresp;
      o_m_rdata[m] = i_s_rdata;
      o_m_rresp[m] = i_s_rresp;
    end
  end

  assign w_aw_hs = o_s_awvalid && i_s_awready;
  assign w_w_hs  = o_s_wvalid && i_s_wready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_gnt_idx   <= '0;
      r_gnt_write <= 1'b0;
      r_last      <= IW'(NUMM - 1);
      r_last_type <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt_idx          <= w_sel;
            r_gnt_write        <= w_sel_write;
            r_last             <= w_sel;
            r_last_type[w_sel] <= w_sel_write;
            r_aw_done          <= 1'b0;
            r_w_done           <= 1'b0;
            r_state            <= w_sel_write ? ST_WR_ADDR : ST_RD_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_WR_RESP;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: if (i_s_bvalid && o_s_bready) r_state <= ST_IDLE;
        ST_RD_ADDR: if (o_s_arvalid && i_s_arready) r_state <= ST_RD_RESP;
        ST_RD_RESP: if (i_s_rvalid && o_s_rready) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt_valid = (r_state != ST_IDLE);
  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_write = r_gnt_write;

endmodule

// File: doc/axi4l_arbiter.md
# axi4l_arbiter

Round-robin AXI4-Lite arbiter that shares one downstream AXI4-Lite slave port between `NUMM` upstream masters (Ibex instruction port, Ibex data port, debug-module SBA). It is the core of the shared-bus interconnect option, the low-area alternative to the crossbar. It sits between the masters and the address decoder. It serialises traffic to one outstanding transaction at a time, read or write, and routes each response back to the master that issued it.

## Interface
- `NUMM`, default 3: number of upstream masters, 2..8.
- `clk` input 1: single clock for all ports.
- `rst` input 1: synchronous reset, active-high.
- `axim[NUMM]` axi4l_if slave side: upstream master ports, AW/W/B/AR/R channels. Index 0 is the highest priority after reset.
- `axis` axi4l_if master side: the shared downstream port.
- `gnt_valid` output 1: a transaction is currently granted.
- `gnt_idx` output $clog2(NUMM): index of the granted master. Valid only while `gnt_valid` is high.
- `gnt_write` output 1: the granted transaction is a write. Valid only while `gnt_valid` is high.

## Operation
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP.
- Request: master m requests a write when `awvalid` is high, and a read when `arvalid` is high. `wvalid` alone is not a request.
- Grant in IDLE:
  - Search masters cyclically, starting at `last+1` mod NUMM. The first requesting master wins.
  - If that master requests both read and write, the type is the opposite of its per-master `last_type` bit. `last_type` resets to read, so write is served first.
  - Register `gnt_idx`, `gnt_write`, `last <= m`, and `last_type[m] <= type`.
  - Next state is WR_ADDR or RD_ADDR.
- Write path (WR_ADDR):
  - Forward master gnt_idx's AW and W channels to `axis`, both combinationally: valid, addr, prot, data and strb forward down; ready returns back up.
  - Track `aw_done` and `w_done` flags. The AW and W handshakes may occur in either order or in the same cycle.
  - Each channel is masked once its flag is set.
  - When both flags are set (including the cycle the last one completes), go to WR_RESP.
- WR_RESP: connect `axis.b*` to the granted master only. On a `bvalid && bready` handshake, go to IDLE.
- Read path:
  - RD_ADDR: forward the AR channel. On an `arvalid && arready` handshake, go to RD_RESP.
  - RD_RESP: forward R. On an `rvalid && rready` handshake, go to IDLE.
- Non-granted masters, and all masters in IDLE, see:
  - `awready`, `wready` and `arready` at 0;
  - `bvalid` and `rvalid` at 0.
- Downstream valids are 0 in IDLE and in every state not listed above.
- Response data and resp codes (OKAY/SLVERR/DECERR) pass through unmodified.
- Requests may be held or withdrawn in IDLE. Once granted, the master must hold its request per AXI rules; the arbiter does not re-arbitrate mid-transaction.
- Reset mid-transaction:
  - State goes to IDLE, `last` goes to NUMM-1, all `last_type` bits go to read, all flags clear.
  - The in-flight transaction is abandoned. No response is delivered to any master.

## Timing
- Reset values:
  - all upstream `*ready` and `*valid` at 0;
  - all downstream `*valid` and `*ready` at 0;
  - `gnt_valid` 0, `gnt_idx` 0, `gnt_write` 0.
- Arbitration latency: one cycle. A request seen in IDLE at cycle t is presented downstream at cycle t+1.
- Single-beat write with zero-wait slave: grant t, AW+W at t+1, B at t+2, IDLE at t+3. The next grant decision is at t+3.
- Read with zero-wait slave: grant t, AR at t+1, R at t+2, IDLE at t+3.
- There is no combinational path from any `axim` valid to a `axis` valid that bypasses the registered grant.
- There is no combinational path from downstream ready to upstream valid.
- `gnt_valid` is high from t+1 until the cycle of the final response handshake, inclusive.
- Only one transaction is outstanding at any time. Throughput is one transaction per 3 cycles minimum.

## Test plan
- Reset, then idle:
  - Stimulus: hold `rst` high for 2 cycles, then low with no requests.
  - Required: all valids and readies are 0 and `gnt_valid`=0 for 10 cycles.
- Single write:
  - Stimulus: master 1 writes 0x12345678 to 0x10000000, strb 0xF, zero-wait slave.
  - Required: `axis` sees exactly one AW/W with those values at t+1.
  - Required: master 1 receives B OKAY at t+2. Masters 0 and 2 never see `bvalid`.
- Simultaneous requests:
  - Stimulus: masters 0, 1 and 2 all assert `arvalid` at the same cycle after reset.
  - Required: grants occur in order 0, 1, 2.
  - Required: each receives its own `rdata` (0xA0, 0xA1, 0xA2 returned by the slave).
  - Required: master 0 requesting again is served after master 2.
- Read/write alternation:
  - Stimulus: master 2 holds both `awvalid` and `arvalid` continuously, 4 transactions.
  - Required: order is write, read, write, read.
- Decoupled AW/W:
  - Stimulus: slave asserts `awready` 3 cycles before `wready`, with W arriving 2 cycles after AW.
  - Required: exactly one AW handshake and one W handshake downstream.
  - Required: no duplicate AW; B is routed to the granted master.
- Reset mid-read:
  - Stimulus: assert `rst` in RD_RESP while the slave is stalling R.
  - Required: no `rvalid` reaches any master.
  - Required: after release, master 0 is granted first.
